// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one SCLK/MOSI pair between the SPI memory engine (requester 0, "mem")
// and the SPI peripheral engine (requester 1, "per"). Explicit req/gnt
// handshake, fixed mem priority with a starvation guard for per, a forced
// turnaround gap after every release and a hold-timeout watchdog.
// Chip selects are not routed here; each engine keeps its own.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no owner, arbitrate eligible requests this cycle
// GNT_MEM  | mem owns SCLK/MOSI until mem_req drops or the watchdog fires
// GNT_PER  | per owns SCLK/MOSI until per_req drops or the watchdog fires
// TURN     | bus parked at CPOL/0 for TURN_CYCLES cycles between owners

module spi_bus_arbiter #(
   parameter int   TURN_CYCLES  = 2,     // 1..15
   parameter int   MAX_STREAK   = 4,     // 1..15
   parameter int   HOLD_TIMEOUT = 4096,  // 0 disables the watchdog
   parameter logic CPOL         = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_req,
   output logic       mem_gnt,
   input  logic       mem_sclk,
   input  logic       mem_mosi,
   input  logic       per_req,
   output logic       per_gnt,
   input  logic       per_sclk,
   input  logic       per_mosi,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic [1:0] bus_owner,
   output logic       timeout_err,
   input  logic       err_clr
);

   localparam logic [3:0]  TURN_LAST  = 4'(TURN_CYCLES - 1);
   localparam logic [3:0]  STREAK_MAX = 4'(MAX_STREAK);
   localparam bit          HOLD_EN    = (HOLD_TIMEOUT != 0);
   // With the watchdog disabled the compare value is never used; keep it
   // at all-ones so the expression stays well defined.
   localparam logic [15:0] HOLD_LAST  = HOLD_EN ? 16'(HOLD_TIMEOUT - 1) : 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GNT_MEM = 2'd1,
      ST_GNT_PER = 2'd2,
      ST_TURN    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  turn_q, turn_d;
   logic [15:0] hold_q, hold_d;
   logic [3:0]  streak_q, streak_d;
   logic        lock_mem_q, lock_mem_d;
   logic        lock_per_q, lock_per_d;
   logic        err_q, err_d;
   logic        mem_gnt_q, per_gnt_q;
   logic [1:0]  owner_q;

   logic        mem_elig;
   logic        per_elig;
   logic        owner_req;
   logic        hold_hit;
   logic        timeout_fire;

   // Eligibility, current owner's request and watchdog terminal compare.
   always_comb begin
      mem_elig  = mem_req & ~lock_mem_q;
      per_elig  = per_req & ~lock_per_q;
      owner_req = (state_q == ST_GNT_MEM) ? mem_req : per_req;
      hold_hit  = HOLD_EN && (hold_q == HOLD_LAST);
   end

   // Next-state, counters, lockout flags and sticky error.
   always_comb begin
      state_d      = state_q;
      turn_d       = turn_q;
      hold_d       = hold_q;
      streak_d     = streak_q;
      lock_mem_d   = lock_mem_q;
      lock_per_d   = lock_per_q;
      err_d        = err_q;
      timeout_fire = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // mem wins ties unless per has already waited out MAX_STREAK
            // back-to-back mem grants.
            if (mem_elig && !(per_elig && (streak_q == STREAK_MAX))) begin
               state_d = ST_GNT_MEM;
               hold_d  = '0;
               if (per_req) begin
                  streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
               end else begin
                  streak_d = '0;
               end
            end else if (per_elig) begin
               state_d  = ST_GNT_PER;
               hold_d   = '0;
               streak_d = '0;
            end
         end

         ST_GNT_MEM, ST_GNT_PER: begin
            // A request drop in the same cycle as the watchdog hit is a
            // clean release: no error, no lockout.
            if (!owner_req) begin
               state_d = ST_TURN;
               turn_d  = TURN_LAST;
            end else if (hold_hit) begin
               state_d      = ST_TURN;
               turn_d       = TURN_LAST;
               timeout_fire = 1'b1;
            end else begin
               hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
            end
         end

         ST_TURN: begin
            if (turn_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               turn_d = turn_q - 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A locked-out requester is released once it lets go of req.
      if (!mem_req) begin
         lock_mem_d = 1'b0;
      end
      if (!per_req) begin
         lock_per_d = 1'b0;
      end
      if (timeout_fire && (state_q == ST_GNT_MEM)) begin
         lock_mem_d = 1'b1;
      end
      if (timeout_fire && (state_q == ST_GNT_PER)) begin
         lock_per_d = 1'b1;
      end

      // Set has priority over clear.
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (timeout_fire) begin
         err_d = 1'b1;
      end
   end

   // State, counters and flags; reset drops any grant without a turnaround.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         turn_q     <= '0;
         hold_q     <= '0;
         streak_q   <= '0;
         lock_mem_q <= 1'b0;
         lock_per_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         turn_q     <= turn_d;
         hold_q     <= hold_d;
         streak_q   <= streak_d;
         lock_mem_q <= lock_mem_d;
         lock_per_q <= lock_per_d;
         err_q      <= err_d;
      end
   end

   // Registered grant/owner outputs decoded from the next state so they
   // line up with state_q cycle for cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_gnt_q <= 1'b0;
         per_gnt_q <= 1'b0;
         owner_q   <= 2'b00;
      end else begin
         mem_gnt_q <= (state_d == ST_GNT_MEM);
         per_gnt_q <= (state_d == ST_GNT_PER);
         case (state_d)
            ST_GNT_MEM: owner_q <= 2'b01;
            ST_GNT_PER: owner_q <= 2'b10;
            default:    owner_q <= 2'b00;
         endcase
      end
   end

   // Zero-latency bus mux; parked at CPOL/0 whenever nobody owns the bus.
   always_comb begin
      spi_sclk = CPOL;
      spi_mosi = 1'b0;
      case (state_q)
         ST_GNT_MEM: begin
            spi_sclk = mem_sclk;
            spi_mosi = mem_mosi;
         end
         ST_GNT_PER: begin
            spi_sclk = per_sclk;
            spi_mosi = per_mosi;
         end
         default: begin
            spi_sclk = CPOL;
            spi_mosi = 1'b0;
         end
      endcase
   end

   assign mem_gnt     = mem_gnt_q;
   assign per_gnt     = per_gnt_q;
   assign bus_owner   = owner_q;
   assign timeout_err = err_q;

endmodule
